// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared types and helpers for the multi-channel PWM DAC
package dac_pkg;

    typedef enum logic {
        ALIGN_LEFT   = 1'b0,
        ALIGN_CENTER = 1'b1
    } align_e;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    // Codes beyond the window length saturate to fully on.
    function automatic int unsigned clamp_code(input int unsigned code, input int unsigned cycles);
        return (code > cycles) ? cycles : code;
    endfunction

endpackage

// File: rtl/dac_channel.sv
// rtl/dac_channel.sv - one PWM output: compares the shared slot counter against the active code
module dac_channel
    import dac_pkg::*;
#(
    parameter int CODE_WIDTH        = 8,
    parameter int CYCLES_PER_WINDOW = 256,
    parameter int CW                = cnt_width(CYCLES_PER_WINDOW)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable_i,
    input  logic [CODE_WIDTH-1:0] code_i,
    input  align_e                mode_i,
    input  logic [CW-1:0]         cnt_i,
    output logic                  pwm_o
);

    localparam logic [CW-1:0] WIN = CW'(CYCLES_PER_WINDOW);

    logic [CW-1:0] clamped;
    logic [CW-1:0] offset;
    logic [CW-1:0] hi_end;
    logic          pwm_d;
    logic          pwm_q;

    // offset + clamped never exceeds the window length, so CW bits suffice.
    always_comb begin
        clamped = CW'(clamp_code(32'(code_i), CYCLES_PER_WINDOW));
        offset  = (WIN - clamped) >> 1;
        hi_end  = offset + clamped;
        pwm_d   = 1'b0;
        if (enable_i) begin
            if (mode_i == ALIGN_CENTER) begin
                pwm_d = (cnt_i >= offset) && (cnt_i < hi_end);
            end else begin
                pwm_d = (cnt_i < clamped);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/dac_multi.sv
// rtl/dac_multi.sv - multi-channel double-buffered PWM DAC with frame handshake and underflow flag
module dac_multi
    import dac_pkg::*;
#(
    parameter int NUM_CHANNELS      = 4,
    parameter int CODE_WIDTH        = 8,
    parameter int CYCLES_PER_WINDOW = 256
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    input  logic                               center_mode,
    input  logic [NUM_CHANNELS*CODE_WIDTH-1:0] sample_data,
    input  logic                               sample_valid,
    output logic                               sample_ready,
    output logic [NUM_CHANNELS-1:0]            pwm,
    output logic                               window_start,
    output logic                               underflow
);

    localparam int            FW   = NUM_CHANNELS * CODE_WIDTH;
    localparam int            CW   = cnt_width(CYCLES_PER_WINDOW);
    localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_WINDOW - 1);

    logic [CW-1:0] cnt_q,      cnt_d;
    logic          run_q,      run_d;
    logic [FW-1:0] buf_q,      buf_d;
    logic          buf_full_q, buf_full_d;
    logic [FW-1:0] active_q,   active_d;
    align_e        mode_q,     mode_d;
    logic          uf_pend_q,  uf_pend_d;
    logic          ws_q,       ws_d;
    logic          uf_q,       uf_d;

    logic xfer;
    logic boundary;

    assign sample_ready = !buf_full_q && run_q;
    assign xfer         = sample_valid && sample_ready;
    assign boundary     = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d      = cnt_q;
        run_d      = 1'b1;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        active_d   = active_q;
        mode_d     = mode_q;
        uf_pend_d  = uf_pend_q;

        if (!enable || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        // Status pulses line up with the registered pwm of slot 0.
        ws_d = enable && (cnt_q == '0);
        uf_d = enable && (cnt_q == '0) && uf_pend_q;

        if (!enable) begin
            uf_pend_d = 1'b0;
        end else if (boundary) begin
            uf_pend_d = !buf_full_q && !xfer;
        end else if (cnt_q == '0) begin
            uf_pend_d = 1'b0;
        end

        // A frame arriving in the boundary cycle with an empty buffer skips the buffer.
        if (boundary) begin
            mode_d = align_e'(center_mode);
            if (buf_full_q) begin
                active_d   = buf_q;
                buf_full_d = 1'b0;
            end else if (xfer) begin
                active_d = sample_data;
            end
        end else if (xfer) begin
            buf_d      = sample_data;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            run_q      <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            active_q   <= '0;
            mode_q     <= ALIGN_LEFT;
            uf_pend_q  <= 1'b0;
            ws_q       <= 1'b0;
            uf_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            run_q      <= run_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            active_q   <= active_d;
            mode_q     <= mode_d;
            uf_pend_q  <= uf_pend_d;
            ws_q       <= ws_d;
            uf_q       <= uf_d;
        end
    end

    assign window_start = ws_q;
    assign underflow    = uf_q;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        dac_channel #(
            .CODE_WIDTH       (CODE_WIDTH),
            .CYCLES_PER_WINDOW(CYCLES_PER_WINDOW),
            .CW               (CW)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .enable_i(enable),
            .code_i  (active_q[i*CODE_WIDTH +: CODE_WIDTH]),
            .mode_i  (mode_q),
            .cnt_i   (cnt_q),
            .pwm_o   (pwm[i])
        );
    end

endmodule

// File: tb/tb_dac_multi.sv
// tb/tb_dac_multi.sv - scoreboard bench for dac_multi (2 channels, 4-bit codes, 8-slot window)
module tb_dac_multi;

    localparam int NCH  = 2;
    localparam int CWID = 4;
    localparam int CPW  = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 enable;
    logic                 center_mode;
    logic [NCH*CWID-1:0]  sample_data;
    logic                 sample_valid;
    logic                 sample_ready;
    logic [NCH-1:0]       pwm;
    logic                 window_start;
    logic                 underflow;

    int         vectors     = 0;
    int         miscompares = 0;
    int         ecnt        = 0;
    logic       mon_en      = 1'b0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    dac_multi #(
        .NUM_CHANNELS     (NCH),
        .CODE_WIDTH       (CWID),
        .CYCLES_PER_WINDOW(CPW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .center_mode (center_mode),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .pwm         (pwm),
        .window_start(window_start),
        .underflow   (underflow)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_bit(input int code, input bit ctr, input int s);
        int c;
        int off;
        c   = (code > CPW) ? CPW : code;
        off = (CPW - c) / 2;
        return ctr ? ((s >= off) && (s < off + c)) : (s < c);
    endfunction

    // Expected {window_start, underflow, pwm[1], pwm[0]} for every slot of one window.
    task automatic push_window(input int c0, input int c1, input bit ctr, input bit uf);
        for (int s = 0; s < CPW; s++) begin
            exp_q.push_back({s == 0, uf && (s == 0), exp_bit(c1, ctr, s), exp_bit(c0, ctr, s)});
        end
    endtask

    function automatic logic [7:0] pack(input logic [3:0] c0, input logic [3:0] c1);
        return {c1, c0};
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                check($sformatf("sb_empty e=%0d", ecnt), 1, 0);
            end else begin
                check($sformatf("slot e=%0d", ecnt), {window_start, underflow, pwm}, exp_q.pop_front());
            end
        end
    end

    task automatic wait_n(input int e);
        int g;
        g = 0;
        while ((ecnt != e) && (g < 500)) begin
            @(negedge clk);
            g++;
        end
        if (ecnt != e) check("wait_timeout", ecnt, e);
    endtask

    task automatic send_one(input logic [7:0] f, input string tag);
        check({tag, "_ready"}, sample_ready, 1);
        sample_data  = f;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic stream(input logic [7:0] f, input int exp_edge, input string tag);
        int n;
        n = 0;
        sample_data = f;
        while (!sample_ready && (n < 40)) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept_edge"}, ecnt + 1, exp_edge);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b1;
        center_mode  = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_pwm", pwm, 0);
        check("rst_ready", sample_ready, 0);
        check("rst_ws", window_start, 0);
        check("rst_uf", underflow, 0);

        push_window(0, 0, 0, 0);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        wait_n(1);
        check("ready_after_release", sample_ready, 1);

        wait_n(2);
        send_one(pack(0, 8), "f_0_8");
        push_window(0, 8, 0, 0);

        wait_n(10);
        send_one(pack(3, 15), "f_3_15");
        push_window(3, 15, 0, 0);

        wait_n(18);
        center_mode = 1'b1;
        send_one(pack(4, 3), "f_4_3c");
        push_window(4, 3, 1, 0);

        wait_n(26);
        center_mode = 1'b0;
        send_one(pack(6, 2), "f_6_2");
        push_window(6, 2, 0, 0);
        push_window(6, 2, 0, 1);

        wait_n(41);
        sample_valid = 1'b1;
        stream(pack(1, 7), 42, "A");
        push_window(1, 7, 0, 0);
        @(negedge clk);
        stream(pack(2, 6), 49, "B");
        push_window(2, 6, 0, 0);
        @(negedge clk);
        stream(pack(7, 1), 57, "C");
        push_window(7, 1, 0, 0);
        push_window(7, 1, 0, 1);
        @(negedge clk);
        sample_valid = 1'b0;

        wait_n(79);
        send_one(pack(5, 5), "bypass");
        push_window(5, 5, 0, 0);
        check("bypass_buf_empty", sample_ready, 1);

        wait_n(85);
        #2 rst_n = 1'b0;
        mon_en = 1'b0;
        #1;
        check("midrst_pwm", pwm, 0);
        check("midrst_ready", sample_ready, 0);
        check("midrst_ws", window_start, 0);
        exp_q.delete();

        @(negedge clk);
        push_window(0, 0, 0, 0);
        push_window(0, 0, 0, 1);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        check("rerun_ready_pre", sample_ready, 0);
        wait_n(1);
        check("rerun_ready_post", sample_ready, 1);

        wait_n(16);
        #1 mon_en = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check("dis_pwm", pwm, 0);
        check("dis_ws", window_start, 0);
        check("dis_uf", underflow, 0);
        check("dis_ready", sample_ready, 1);
        enable = 1'b1;
        @(negedge clk);
        check("en_rise_ws", window_start, 1);
        check("en_rise_uf", underflow, 0);
        check("sb_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dac_multi.md
# dac_multi

Multi-channel, double-buffered PWM DAC, the parametrised successor to the single-channel `dac`. It drives `NUM_CHANNELS` PWM outputs from one shared window counter. It accepts a whole frame of channel codes over a valid/ready handshake and applies it atomically at the next window boundary. Alignment is selectable per window (left- or center-aligned), and it flags underflow when no frame is waiting at a boundary.

## Interface
- `NUM_CHANNELS`, default 4: number of PWM outputs, at least 1.
- `CODE_WIDTH`, default 8: bits per channel code.
- `CYCLES_PER_WINDOW`, default 256: clock cycles per PWM window, at least 2, at most 2^`CODE_WIDTH`.
- `clk` input, 1 bit: the single clock; all logic is rising-edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `enable` input, 1 bit: run the window counter.
- `center_mode` input, 1 bit: alignment, 0 = left, 1 = center; sampled at each boundary.
- `sample_data` input, `NUM_CHANNELS*CODE_WIDTH` bits: one frame; channel i occupies bits [i*`CODE_WIDTH` +: `CODE_WIDTH`].
- `sample_valid` input, 1 bit: frame offered.
- `sample_ready` output, 1 bit: frame buffer can accept.
- `pwm` output, `NUM_CHANNELS` bits: registered PWM outputs.
- `window_start` output, 1 bit: one-cycle pulse while `pwm` shows slot 0.
- `underflow` output, 1 bit: one-cycle pulse at a boundary with no frame available.

## Operation
- Window counter `cnt` runs 0..`CYCLES_PER_WINDOW`-1 and wraps. A boundary is the cycle with `enable`=1 and `cnt`=`CYCLES_PER_WINDOW`-1.
- Storage is one holding buffer (frame plus `buf_full` flag), one active code set, and an active mode bit.
- Handshake:
  - `sample_ready` = !`buf_full` && `run`, where `run` is a flop that resets to 0 and sets on the first edge after reset release.
  - A transfer occurs on an edge where `sample_valid` && `sample_ready`.
  - `sample_data` must be held stable while `sample_valid`=1 and `sample_ready`=0.
- A transfer in a non-boundary cycle writes the frame to the buffer and sets `buf_full`.
- At a boundary edge, exactly one of the following applies:
  - If `buf_full`=1: the buffer moves to the active codes and `buf_full` clears.
  - If `buf_full`=0 and a transfer occurs in that cycle: the frame bypasses into the active codes; `buf_full` stays 0; no underflow.
  - If `buf_full`=0 and no transfer: the active codes hold; `underflow` pulses on the next cycle.
  - In every case, the active mode is loaded from `center_mode`.
- Code clamp: c = min(code, `CYCLES_PER_WINDOW`).
- Left-aligned: `pwm`[i] is high for slot s when s < c.
- Center-aligned: with off = (`CYCLES_PER_WINDOW` - c) >> 1 (floor), `pwm`[i] is high when off <= s < off + c.
- Arithmetic uses an unsigned width of clog2(`CYCLES_PER_WINDOW`+1) bits; there are no signed operations.
- `enable`=0:
  - `cnt` is forced to 0, `pwm` to 0, and `window_start`/`underflow` to 0.
  - No boundary events occur.
  - The handshake still fills the buffer.
- Reset (asynchronous, valid mid-window):
  - `cnt`=0, active codes 0, active mode left, `buf_full`=0, `run`=0.
  - Outputs: `pwm`=0, `window_start`=0, `underflow`=0, `sample_ready`=0.
  - After release with `enable`=1, the first output window starts at slot 0.

## Timing
- `pwm`, `window_start` and `underflow` are registered. Output for slot s appears the cycle after `cnt`=s, so the latency from `cnt` to pins is 1 cycle.
- A frame applied at a boundary edge first affects the output at slot 0, the cycle `window_start`=1, so codes never change mid-window.
- Minimum frame throughput is one per window. The buffer gives one window of slack.
- `underflow` is asserted coincident with `window_start` for the window that repeats old codes.
- When `enable` rises, `cnt` starts at 0 on that cycle and `window_start` pulses one cycle later.

## Structure
- Package `dac_pkg` holds:
  - `align_e` enum (`ALIGN_LEFT`, `ALIGN_CENTER`).
  - Function `clamp_code`.
  - Function `cnt_width(cycles)` = clog2(cycles+1).
- Sub-module `dac_channel` is instanced `NUM_CHANNELS` times. It takes the active code, active mode and `cnt`, and produces the registered `pwm` bit.
- Top `dac_multi` owns the counter, handshake buffer, boundary logic and status pulses.

## Test plan
Bench configuration: `NUM_CHANNELS`=2, `CODE_WIDTH`=4, `CYCLES_PER_WINDOW`=8.
- Frame {ch0=0, ch1=8}, left mode -> ch0 low and ch1 high for all 8 slots; `window_start` every 8 cycles.
- Frame {ch0=3, ch1=15}, left mode -> ch0 high in slots 0-2 and low in 3-7; ch1 clamped to full-on.
- Center mode, frame {ch0=4, ch1=3} -> ch0 high in slots 2-5; ch1 high in slots 2-4.
- One frame then `sample_valid`=0 -> `underflow` pulses with the next `window_start`; ch0 repeats the previous pattern; no further change.
- Three back-to-back frames A, B, C held valid:
  - A is accepted, then `sample_ready`=0 until the boundary.
  - A goes active at slot 0, then B is accepted; C waits one window.
  - No underflow.
- Offer frame {5,5} exactly in the boundary cycle with the buffer empty -> bypass applies it at the next slot 0 with no `underflow`.
- Assert `rst_n`=0 at slot 4 -> `pwm`=0 and `sample_ready`=0 immediately. After release, `sample_ready`=1 after one edge, and output restarts at slot 0 with codes 0.
